csa_accumulator: RTL



---
 rtl/fpu_defs_fmac.sv | 11 +
 rtl/csa_row.sv | 18 +
 rtl/csa_accumulator.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fpu_defs_fmac.sv
// rtl/fpu_defs_fmac.sv - shared fmac datapath types
package fpu_defs_fmac;

  // Accumulator control phases: fold operands, resolve redundant form, present result
  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } csa_acc_state_t;

endpackage

// File: rtl/csa_row.sv
// rtl/csa_row.sv - n-bit combinational 3:2 carry-save compressor row
module csa_row #(
  parameter int unsigned n = 8
) (
  input  logic [n-1:0] A_DI,
  input  logic [n-1:0] B_DI,
  input  logic [n-1:0] C_DI,
  output logic [n-1:0] Sum_DO,
  output logic [n-1:0] Carry_DO
);

  // Bitwise full-adder row; Carry_DO is unshifted majority, the caller aligns it
  always_comb begin
    Sum_DO   = A_DI ^ B_DI ^ C_DI;
    Carry_DO = (A_DI & B_DI) | (A_DI & C_DI) | (B_DI & C_DI);
  end

endmodule

// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - handshaked carry-save accumulator with chunked final resolve
module csa_accumulator
  import fpu_defs_fmac::*;
#(
  parameter int unsigned WIDTH = 49,
  parameter int unsigned GUARD = 8,
  parameter int unsigned CHUNK = 16,
  parameter int unsigned CNTW  = 16
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RI,
  input  logic                   Clear_SI,
  input  logic                   In_Valid_SI,
  output logic                   In_Ready_SO,
  input  logic [WIDTH-1:0]       In_Data_DI,
  input  logic                   In_Last_SI,
  output logic                   Out_Valid_SO,
  input  logic                   Out_Ready_SI,
  output logic [WIDTH+GUARD-1:0] Out_Result_DO,
  output logic [CNTW-1:0]        Out_Count_DO
);

  localparam int unsigned ACCW   = WIDTH + GUARD;
  localparam int unsigned NCHUNK = (ACCW + CHUNK - 1) / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  csa_acc_state_t   state_q, state_d;
  logic [ACCW-1:0]  sum_q, sum_d;
  logic [ACCW-1:0]  carry_q, carry_d;
  logic [ACCW-1:0]  result_q, result_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [KW-1:0]    k_q, k_d;
  logic             cin_q, cin_d;

  logic [ACCW-1:0]  x_ext;
  logic [ACCW-1:0]  row_sum;
  logic [ACCW-1:0]  row_maj;
  logic [ACCW-1:0]  carry_shifted;
  logic             unused_carry_msb;
  logic             in_accept;
  logic [CHUNK-1:0] s_chunk;
  logic [CHUNK-1:0] c_chunk;
  logic [CHUNK:0]   chunk_add;

  assign x_ext = ACCW'(In_Data_DI);

  csa_row #(
    .n (ACCW)
  ) i_row (
    .A_DI     (sum_q),
    .B_DI     (carry_q),
    .C_DI     (x_ext),
    .Sum_DO   (row_sum),
    .Carry_DO (row_maj)
  );

  // Carry word is weighted one bit up; the bit shifted out is beyond 2^ACCW and dropped
  assign carry_shifted    = {row_maj[ACCW-2:0], 1'b0};
  assign unused_carry_msb = row_maj[ACCW-1];

  assign In_Ready_SO   = (state_q == ACCUM) && !Clear_SI;
  assign in_accept     = In_Valid_SI && In_Ready_SO;
  assign Out_Valid_SO  = (state_q == DONE);
  assign Out_Result_DO = result_q;
  assign Out_Count_DO  = count_q;

  // Pick chunk k of the redundant pair; bits past ACCW in the top chunk read as zero
  always_comb begin
    s_chunk = '0;
    c_chunk = '0;
    for (int i = 0; i < int'(ACCW); i++) begin
      if (i / int'(CHUNK) == int'(k_q)) begin
        s_chunk[i % int'(CHUNK)] = sum_q[i];
        c_chunk[i % int'(CHUNK)] = carry_q[i];
      end
    end
    chunk_add = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, cin_q};
  end

  // Next-state and datapath update; Clear_SI overrides every phase
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    result_d = result_q;
    count_d  = count_q;
    k_d      = k_q;
    cin_d    = cin_q;
    if (Clear_SI) begin
      state_d = ACCUM;
      sum_d   = '0;
      carry_d = '0;
      count_d = '0;
      k_d     = '0;
      cin_d   = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (in_accept) begin
            sum_d   = row_sum;
            carry_d = carry_shifted;
            if (count_q != {CNTW{1'b1}}) count_d = count_q + 1'b1;
            if (In_Last_SI) begin
              state_d = RESOLVE;
              k_d     = '0;
              cin_d   = 1'b0;
            end
          end
        end
        RESOLVE: begin
          for (int i = 0; i < int'(ACCW); i++) begin
            if (i / int'(CHUNK) == int'(k_q)) result_d[i] = chunk_add[i % int'(CHUNK)];
          end
          if (k_q == KW'(NCHUNK - 1)) begin
            state_d = DONE;
            k_d     = '0;
            cin_d   = 1'b0;
          end else begin
            k_d   = k_q + 1'b1;
            cin_d = chunk_add[CHUNK];
          end
        end
        DONE: begin
          if (Out_Ready_SI) begin
            state_d = ACCUM;
            sum_d   = '0;
            carry_d = '0;
            count_d = '0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // State registers with synchronous reset back to an empty ACCUM phase
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q  <= ACCUM;
      sum_q    <= '0;
      carry_q  <= '0;
      result_q <= '0;
      count_q  <= '0;
      k_q      <= '0;
      cin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      count_q  <= count_d;
      k_q      <= k_d;
      cin_q    <= cin_d;
    end
  end

endmodule
